mem_credit_arbiter: RTL and testbench
=====================================

// Module: mem_credit_arbiter
// PURPOSE
//  Shares the single memory-network issue port among NPORT pipeline requesters using round-robin.
//  Enforces the memory network credit limit: holds a credit counter initialised to MAXCREDIT.
//  Sits between the pipelines' memory request stages and the memory controller network interface.
// PARAMETERS
//  NPORT      4   number of requesting pipelines (= NMEMCTRLPORT in DIAB build)
//  MAXCREDIT  64  memory network credits (= MAXMEMCREDIT)
//  CNTW       7   credit counter width (= MAXMEMCREDITMSB+1)
//  PAYLOADW   64  request payload width (addr/cmd/tid, opaque to this block)
// PORTS
//  gclk         in   1               clock
//  rstn         in   1               asynchronous reset, active low
//  req_valid    in   NPORT           request pending, per port
//  req_payload  in   NPORT*PAYLOADW  port i at [i*PAYLOADW +: PAYLOADW]
//  req_ready    out  NPORT           one-hot grant; transfer when req_valid[i] & req_ready[i]
//  mem_valid    out  1               request issued to memory network (registered)
//  mem_payload  out  PAYLOADW        payload of issued request (registered)
//  credit_ret   in   1               one credit returned this cycle
//  credit_cnt   out  CNTW            current credits available
//  credit_ovf   out  1               sticky error: credit returned while counter full
// BEHAVIOUR
//  Reset (rstn low, async): credit_cnt=MAXCREDIT, mem_valid=0, mem_payload=0, credit_ovf=0,
//   rr_ptr=NPORT-1 (so port 0 has priority first); req_ready forced 0 while rstn low.
//  Grant (combinational): if credit_cnt!=0, req_ready = one-hot of first port with req_valid set,
//   searching rr_ptr+1, rr_ptr+2 ... wrapping modulo NPORT; else req_ready=0.
//   req_ready never asserted to a port with req_valid=0.
//  Issue: on a grant, next edge sets mem_valid=1, mem_payload=granted payload, rr_ptr=granted index.
//   No grant -> mem_valid=0 next cycle, mem_payload holds. Latency request->mem_valid: 1 cycle.
//   At most one issue per cycle; network has no backpressure beyond credits.
//  Credits: grant only -> cnt-1; credit_ret only -> cnt+1; both same cycle -> unchanged.
//   cnt==0: no grant; credit_ret raises cnt to 1, grant possible next cycle (no same-cycle bypass).
//   credit_ret at cnt==MAXCREDIT with no grant -> cnt stays MAXCREDIT, credit_ovf<=1 (sticky to reset).
//   Counter never wraps below 0 or above MAXCREDIT.
//  rr_ptr unchanged on cycles without grant; pointer wraps NPORT-1 -> 0.
//  Requester rules: req_payload stable while req_valid high and not granted; req_valid may drop
//   without a grant (no grant is lost; arbitration re-evaluated every cycle).
//  Reset mid-operation: registered issue dropped, credits restored to MAXCREDIT; in-flight
//   network credits are owned by the network reset, not reconciled here.
// CONFIGURATION
//  MEMARB_PERF_EN defined: adds outputs stall_cycles[31:0] (cycles with |req_valid and cnt==0)
//   and issue_total[31:0] (count of issues); both reset to 0, wrap at 2^32, no saturation.
//  MEMARB_PERF_EN undefined: these ports and counters are absent; all other behaviour identical.
// TESTING
//  1 reset: rstn low mid-cycle -> immediately credit_cnt=64, mem_valid=0, req_ready=0, credit_ovf=0.
//  2 port0 valid continuously, no credit_ret -> 64 grants on consecutive cycles, credit_cnt=0,
//    65th cycle req_ready=0; one credit_ret pulse -> exactly one more grant the following cycle.
//  3 all 4 ports valid, credits plenty -> grant order 0,1,2,3,0,1; mem_payload matches per port
//    one cycle after each grant.
//  4 ports 1,3 valid only, rr_ptr=1 -> grants 3,1,3; dropping port3 valid -> 1,1,1.
//  5 credit_cnt=10, grant and credit_ret same cycle -> cnt stays 10; credit_ret at 64 with no
//    grant -> cnt=64, credit_ovf=1, held until reset.
//  6 MEMARB_PERF_EN: 5 cycles of req_valid at cnt=0 -> stall_cycles=5; after test 3 six issues
//    -> issue_total=6; without macro, bench compiles without these ports.

Source files
------------

// File: rtl/mem_credit_arbiter.sv
// mem_credit_arbiter
//   Round-robin arbiter that shares one memory-network issue port among
//   NPORT pipeline requesters and enforces the network credit limit.
//   Sits between the pipelines' memory request stages and the memory
//   controller network interface.
//
// Ports
//   gclk         in   clock
//   rstn         in   asynchronous reset, active low
//   req_valid    in   [NPORT]           request pending, per port
//   req_payload  in   [NPORT*PAYLOADW]  port i at [i*PAYLOADW +: PAYLOADW]
//   req_ready    out  [NPORT]           one-hot grant (transfer on valid & ready)
//   mem_valid    out                    registered issue strobe to the network
//   mem_payload  out  [PAYLOADW]        registered payload of the issued request
//   credit_ret   in                     one credit returned this cycle
//   credit_cnt   out  [CNTW]            credits currently available
//   credit_ovf   out                    sticky: credit returned while counter full
//
// Optional build macro
//   MEMARB_PERF_EN  adds stall_cycles[31:0] (cycles with any request pending
//                   and no credit) and issue_total[31:0] (issues); both
//                   free-running, wrap at 2^32.

module mem_credit_arbiter #(
  parameter int NPORT     = 4,
  parameter int MAXCREDIT = 64,
  parameter int CNTW      = 7,
  parameter int PAYLOADW  = 64
) (
  input  logic                      gclk,
  input  logic                      rstn,
  input  logic [NPORT-1:0]          req_valid,
  input  logic [NPORT*PAYLOADW-1:0] req_payload,
  output logic [NPORT-1:0]          req_ready,
  output logic                      mem_valid,
  output logic [PAYLOADW-1:0]       mem_payload,
  input  logic                      credit_ret,
  output logic [CNTW-1:0]           credit_cnt,
  output logic                      credit_ovf
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               issue_total
`endif
);

  localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [CNTW-1:0] CREDIT_FULL = CNTW'(MAXCREDIT);

  logic [PTRW-1:0]     rr_ptr_reg;
  logic [CNTW-1:0]     credit_cnt_reg;
  logic [CNTW-1:0]     credit_cnt_next;
  logic                credit_ovf_reg;
  logic                credit_ovf_next;
  logic                mem_valid_reg;
  logic [PAYLOADW-1:0] mem_payload_reg;

  logic                grant_any;
  logic [PTRW-1:0]     grant_idx;
  logic [NPORT-1:0]    grant_oh;
  int                  scan_idx;

  logic [PAYLOADW-1:0] payload_arr [NPORT];

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
      assign payload_arr[gi] = req_payload[gi*PAYLOADW +: PAYLOADW];
    end
  endgenerate

  // Search starts one past the last winner, so the last winner has lowest
  // priority. No credit means no grant at all; a returned credit only
  // becomes usable on the following cycle.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NPORT; k++) begin
      scan_idx = (int'(rr_ptr_reg) + k) % NPORT;
      if (!grant_any && (credit_cnt_reg != '0) && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = PTRW'(scan_idx);
      end
    end
    if (grant_any) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Grant and return in the same cycle cancel out. A return with the
  // counter already full is dropped and flagged rather than wrapping.
  always_comb begin
    credit_cnt_next = credit_cnt_reg;
    credit_ovf_next = credit_ovf_reg;
    if (grant_any && !credit_ret) begin
      credit_cnt_next = credit_cnt_reg - CNTW'(1);
    end else if (!grant_any && credit_ret) begin
      if (credit_cnt_reg == CREDIT_FULL) begin
        credit_ovf_next = 1'b1;
      end else begin
        credit_cnt_next = credit_cnt_reg + CNTW'(1);
      end
    end
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_reg      <= PTRW'(NPORT - 1);
      credit_cnt_reg  <= CREDIT_FULL;
      credit_ovf_reg  <= 1'b0;
      mem_valid_reg   <= 1'b0;
      mem_payload_reg <= '0;
    end else begin
      credit_cnt_reg <= credit_cnt_next;
      credit_ovf_reg <= credit_ovf_next;
      mem_valid_reg  <= grant_any;
      if (grant_any) begin
        rr_ptr_reg      <= grant_idx;
        mem_payload_reg <= payload_arr[grant_idx];
      end
    end
  end

  // Grants are masked while reset is held so nothing is handed out that
  // the registers could not capture.
  assign req_ready   = grant_oh & {NPORT{rstn}};
  assign mem_valid   = mem_valid_reg;
  assign mem_payload = mem_payload_reg;
  assign credit_cnt  = credit_cnt_reg;
  assign credit_ovf  = credit_ovf_reg;

`ifdef MEMARB_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] issue_total_reg;

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles_reg <= '0;
      issue_total_reg  <= '0;
    end else begin
      if ((|req_valid) && (credit_cnt_reg == '0)) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (grant_any) begin
        issue_total_reg <= issue_total_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign issue_total  = issue_total_reg;
`endif

endmodule

// File: tb/tb_mem_credit_arbiter.sv
// tb_mem_credit_arbiter
//   Self-checking bench for mem_credit_arbiter. A reference model of the
//   round-robin pointer and credit counter predicts each cycle's grant;
//   the predicted payload is pushed to a scoreboard queue and popped when
//   the registered issue appears one cycle later.
//   Build with +define+MEMARB_PERF_EN to also check the perf counters.

module tb_mem_credit_arbiter;

  localparam int NPORT     = 4;
  localparam int MAXCREDIT = 64;
  localparam int CNTW      = 7;
  localparam int PAYLOADW  = 64;

  logic                      gclk = 1'b0;
  logic                      rstn = 1'b0;
  logic [NPORT-1:0]          req_valid = '0;
  logic [NPORT*PAYLOADW-1:0] req_payload = '0;
  logic [NPORT-1:0]          req_ready;
  logic                      mem_valid;
  logic [PAYLOADW-1:0]       mem_payload;
  logic                      credit_ret = 1'b0;
  logic [CNTW-1:0]           credit_cnt;
  logic                      credit_ovf;
`ifdef MEMARB_PERF_EN
  logic [31:0]               stall_cycles;
  logic [31:0]               issue_total;
`endif

  always #5 gclk = ~gclk;

  mem_credit_arbiter #(
    .NPORT(NPORT), .MAXCREDIT(MAXCREDIT), .CNTW(CNTW), .PAYLOADW(PAYLOADW)
  ) dut (
    .gclk(gclk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_payload(req_payload),
    .req_ready(req_ready),
    .mem_valid(mem_valid),
    .mem_payload(mem_payload),
    .credit_ret(credit_ret),
    .credit_cnt(credit_cnt),
    .credit_ovf(credit_ovf)
`ifdef MEMARB_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .issue_total(issue_total)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int                  m_cnt;
  int                  m_ptr;
  logic                m_ovf;
  logic [PAYLOADW-1:0] m_last_pay;
  int                  m_stall;
  int                  m_issue;
  logic [PAYLOADW-1:0] sb_q [$];
  logic [PAYLOADW-1:0] pay [NPORT];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt      = MAXCREDIT;
    m_ptr      = NPORT - 1;
    m_ovf      = 1'b0;
    m_last_pay = '0;
    m_stall    = 0;
    m_issue    = 0;
    sb_q.delete();
  endtask

  // Called just after a negedge: pulls rstn low mid-cycle with requests
  // pending, checks the immediate reset state, releases on the next negedge.
  task automatic do_reset();
    #2;
    rstn       = 1'b0;
    req_valid  = '1;
    credit_ret = 1'b0;
    #1;
    check_eq("rst_credit_cnt", 64'(credit_cnt), 64'(MAXCREDIT));
    check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("rst_mem_payload", 64'(mem_payload), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_credit_ovf", 64'(credit_ovf), 64'd0);
`ifdef MEMARB_PERF_EN
    check_eq("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    check_eq("rst_issue_total", 64'(issue_total), 64'd0);
`endif
    model_reset();
    @(negedge gclk);
    rstn      = 1'b1;
    req_valid = '0;
    $display("reset applied and released t=%0t", $time);
  endtask

  // One clock cycle: drive inputs after negedge, check combinational grant,
  // advance the model, then check the registered issue after the posedge.
  task automatic cycle(input logic [NPORT-1:0] v, input logic ret);
    int g;
    logic [NPORT-1:0]    exp_oh;
    logic [PAYLOADW-1:0] exp_pay;
    req_valid  = v;
    credit_ret = ret;
    for (int i = 0; i < NPORT; i++) req_payload[i*PAYLOADW +: PAYLOADW] = pay[i];
    #1;
    g = -1;
    if (m_cnt != 0) begin
      for (int k = 1; k <= NPORT; k++) begin
        int idx;
        idx = (m_ptr + k) % NPORT;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_oh = '0;
    if (g >= 0) exp_oh[g] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_oh));
    check_eq("credit_cnt", 64'(credit_cnt), 64'(m_cnt));
    check_eq("credit_ovf", 64'(credit_ovf), 64'(m_ovf));
    if (g >= 0) sb_q.push_back(pay[g]);

    if (v != '0 && m_cnt == 0) m_stall++;
    if (g >= 0 && !ret) begin
      m_cnt--;
    end else if (g < 0 && ret) begin
      if (m_cnt == MAXCREDIT) m_ovf = 1'b1;
      else m_cnt++;
    end
    if (g >= 0) begin
      m_ptr = g;
      m_issue++;
    end

    @(posedge gclk);
    #1;
    check_eq("mem_valid", 64'(mem_valid), (g >= 0) ? 64'd1 : 64'd0);
    if (g >= 0) begin
      exp_pay = sb_q.pop_front();
      m_last_pay = exp_pay;
      check_eq("mem_payload", mem_payload, exp_pay);
      $display("issue port=%0d payload=%h credits_left=%0d", g, mem_payload, m_cnt);
      pay[g] = {$urandom, $urandom};
    end else begin
      check_eq("mem_payload_hold", mem_payload, m_last_pay);
    end
`ifdef MEMARB_PERF_EN
    check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    check_eq("issue_total", 64'(issue_total), 64'(m_issue));
`endif
    @(negedge gclk);
  endtask

  initial begin
    for (int i = 0; i < NPORT; i++) pay[i] = {32'hC0DE_0000 + 32'(i), $urandom};
    model_reset();
    @(negedge gclk);
    do_reset();

    // all ports busy: order 0,1,2,3,0,1
    repeat (6) cycle(4'b1111, 1'b0);
`ifdef MEMARB_PERF_EN
    check_eq("issue_total_six", 64'(issue_total), 64'd6);
`endif

    // pointer now at 1; ports 1,3 -> 3,1,3; then only port 1 -> 1,1,1
    repeat (3) cycle(4'b1010, 1'b0);
    repeat (3) cycle(4'b0010, 1'b0);

    // reset in the middle of traffic
    cycle(4'b1111, 1'b0);
    do_reset();

    // port 0 drains all credits, then starves
    repeat (MAXCREDIT) cycle(4'b0001, 1'b0);
    check_eq("credits_drained", 64'(credit_cnt), 64'd0);
    repeat (5) cycle(4'b0001, 1'b0);
`ifdef MEMARB_PERF_EN
    check_eq("stall_five", 64'(stall_cycles), 64'd5);
`endif
    cycle(4'b0001, 1'b1);  // return lands, no same-cycle grant
    cycle(4'b0001, 1'b0);  // exactly one grant
    cycle(4'b0001, 1'b0);  // starved again

    // refill to 10, then grant and return together
    repeat (10) cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b0);
    check_eq("cnt_ten", 64'(credit_cnt), 64'd10);

    // refill to full, over-return sets the sticky flag
    repeat (MAXCREDIT - 10) cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    check_eq("ovf_set", 64'(credit_ovf), 64'd1);
    check_eq("cnt_full", 64'(credit_cnt), 64'(MAXCREDIT));
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    check_eq("ovf_sticky", 64'(credit_ovf), 64'd1);

    do_reset();
    cycle(4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
